algo_mrmw_qocc_mon: RTL
=======================

Name: algo_mrmw_qocc_mon

Overview:
- Synthesisable per-queue occupancy monitor for linked-list queue IPs with NUMPUPT push ports and NUMPOPT pop ports.
- Tracks the live count of every queue and detects pops from empty queues (underflow) and pushes beyond a per-queue capacity (overflow).
- Captures the first error and counts all error events.
- Exposes counts through a read-only CPU port; sits beside the queue algo core and snoops its push/pop bus.

Parameters:
- NUMQPRT, 64, number of queues
- BITQPRT, 6, queue-id width
- NUMADDR, 8192, total entries; default per-queue cap
- BITADDR, 13, address width; counts are BITADDR+1 bits
- NUMPUPT, 2, push ports
- NUMPOPT, 2, pop ports
- QCAP, NUMADDR, per-queue overflow threshold (1..NUMADDR)
- BITECNT, 8, error-event counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ready  in  1  core ready; push/pop ignored while low
- push  in  NUMPUPT  per-port push strobe
- pu_prt  in  NUMPUPT*BITQPRT  push queue ids, port i at bits [i*BITQPRT +: BITQPRT]
- pop  in  NUMPOPT  per-port pop strobe
- po_prt  in  NUMPOPT*BITQPRT  pop queue ids, same packing as pu_prt
- err_clr  in  1  clears sticky flags, capture register and error counter
- cp_read  in  1  CPU count read
- cp_adr  in  BITQPRT  queue id to read
- cp_vld  out  1  read data valid
- cp_dout  out  BITADDR+1  occupancy of queue cp_adr
- occ_total  out  BITADDR+1  sum of all queue counts
- err_uflow  out  1  sticky underflow flag
- err_oflow  out  1  sticky overflow flag
- err_vld  out  1  first-error capture valid
- err_prt  out  BITQPRT  queue id of first error
- err_type  out  1  first error type: 0 = underflow, 1 = overflow
- err_cnt  out  BITECNT  saturating error-event count

Behaviour:
- Reset (rst=0, asynchronous): all counts 0; every output 0.
- Per cycle with ready=1, for each queue q:
  - P = number of push ports targeting q; D = number of pop ports targeting q.
  - Pops are checked against the registered count only; there is no same-cycle push bypass.
  - Underflow when D > occ[q]. Effective pops = min(D, occ[q]), so the count never goes below 0.
  - nxt = occ[q] + P − effective pops.
  - Overflow when nxt > QCAP; the count saturates at QCAP.
  - Both conditions can occur in the same cycle on the same queue.
- With ready=0: counts hold; no errors raised.
- Events per cycle = number of queues in error (underflow + overflow counted separately).
- err_cnt adds the event count each cycle and saturates at all-ones.
- Sticky flags set on the cycle after detection.
- First-error capture:
  - When err_vld=0 and errors occur, capture the lowest-numbered erroring queue; underflow outranks overflow on that queue.
  - err_vld then holds until err_clr.
- err_clr has priority over a same-cycle new error; the new error is dropped.
- occ_total is registered and updated in the same cycle as the counts. Width rule: it cannot exceed NUMQPRT*QCAP, and BITADDR+1 bits suffice only when NUMQPRT*QCAP ≤ 2^(BITADDR+1)−1; otherwise it saturates.
- CPU read: cp_vld=1 exactly one cycle after cp_read. cp_dout is the count registered at the cycle cp_read is sampled (post-update values from that edge). cp_dout holds between reads; cp_vld is a one-cycle pulse.
- Reset asserted mid-operation: everything clears immediately; in-flight reads are lost (no cp_vld).

Optional Feature:
- Macro QOCC_MON_SVA_EN.
- When defined, concurrent assertions are compiled in, disabled iff (!rst || !ready):
  - pop to a queue at zero count;
  - nxt > QCAP;
  - cp_vld not exactly one cycle after cp_read.
  - Each assertion prints [ERROR:memoir:%m:%0t] with the queue id.
- When undefined: no assertion code; RTL behaviour is identical.

Decomposition:
- Package qocc_pkg holds:
  - err_type enum (ERR_UFLOW, ERR_OFLOW);
  - function count_hits(vector, ids, q) returning the number of ports targeting q;
  - saturating-add helper.
- One sub-module, qocc_lane: a single queue's counter, update arithmetic and error detect. Generated NUMQPRT times.
- The top level holds the capture priority encoder, err_cnt, occ_total and the CPU read mux.

Test Plan:
- Push q3 on both ports for 2 cycles, then pop q3 on both ports: occ[3] goes 2→4→2; cp_read q3 → cp_dout=2 one cycle later; no errors.
- Pop q5 at count 0: err_uflow=1, err_vld=1, err_prt=5, err_type=0, err_cnt=1; occ[5] stays 0.
- QCAP=4, q7 at 3, push q7 on both ports: err_oflow=1, occ[7]=4, err_prt=7, err_type=1.
- Same cycle: pop q2 (empty) and pop q9 (empty): err_cnt+=2, err_prt=2; err_clr with a simultaneous new error → all cleared, err_cnt=0.
- Push q1 with ready=0: counts and flags unchanged. Assert rst low mid-sequence → all outputs 0 immediately.
- Push port 0 to q4 while pop port 1 hits q4 at count 1: occ[4] stays 1, no error.

Source files
------------

// File: rtl/qocc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qocc_pkg
// Description : Shared types and helpers for the queue occupancy monitor:
//               the error-type encoding, a port-hit counter and a saturating
//               adder.
// Revision    : 1.0 - initial release
// ============================================================================
package qocc_pkg;

    // Fixed stride used to pass any port vector / id bundle to count_hits
    localparam int C_MAX_PORTS = 16;
    localparam int C_MAX_QBITS = 16;

    typedef enum logic {
        ERR_UFLOW = 1'b0,
        ERR_OFLOW = 1'b1
    } err_type_e;

    // Number of strobed ports whose queue id equals q (ids at a C_MAX_QBITS stride)
    function automatic logic [31:0] count_hits(
        input logic [C_MAX_PORTS-1:0]             vec,
        input logic [C_MAX_PORTS*C_MAX_QBITS-1:0] ids,
        input logic [C_MAX_QBITS-1:0]             q
    );
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < C_MAX_PORTS; i++) begin
            if (vec[i] && (ids[i*C_MAX_QBITS +: C_MAX_QBITS] == q)) begin
                n = n + 32'd1;
            end
        end
        return n;
    endfunction

    // a + b clamped to lim
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] lim
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/qocc_lane.sv
`default_nettype none
// ============================================================================
// Module      : qocc_lane
// Description : Occupancy counter for one queue. Counts push/pop hits on the
//               snooped bus, clamps at zero (underflow) and at QCAP
//               (overflow), and flags both conditions combinationally.
//               Optional assertions under QOCC_MON_SVA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qocc_lane
    import qocc_pkg::*;
#(
    parameter int QID     = 0,
    parameter int BITQPRT = 6,
    parameter int BITADDR = 13,
    parameter int NUMPUPT = 2,
    parameter int NUMPOPT = 2,
    parameter int QCAP    = 8192
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMPUPT-1:0]         push,
    input  logic [NUMPUPT*BITQPRT-1:0] pu_prt,
    input  logic [NUMPOPT-1:0]         pop,
    input  logic [NUMPOPT*BITQPRT-1:0] po_prt,
    output logic [BITADDR:0]           occ_nxt,
    output logic                       uflow,
    output logic                       oflow
);

    localparam logic [C_MAX_QBITS-1:0] C_QID  = C_MAX_QBITS'(QID);
    localparam logic [31:0]            C_QCAP = 32'(QCAP);

    logic [C_MAX_PORTS-1:0]             w_push_ext;
    logic [C_MAX_PORTS-1:0]             w_pop_ext;
    logic [C_MAX_PORTS*C_MAX_QBITS-1:0] w_pu_ids;
    logic [C_MAX_PORTS*C_MAX_QBITS-1:0] w_po_ids;
    logic [31:0]                        w_p;
    logic [31:0]                        w_d;
    logic [31:0]                        w_occ;
    logic [31:0]                        w_eff;
    logic [31:0]                        w_sum;
    logic [BITADDR:0]                   occ_d;
    logic [BITADDR:0]                   occ_q;

    // Re-pack the bus onto the fixed stride the hit counter expects
    always_comb begin
        w_push_ext = '0;
        w_pop_ext  = '0;
        w_pu_ids   = '0;
        w_po_ids   = '0;
        for (int i = 0; i < NUMPUPT; i++) begin
            w_push_ext[i]                        = push[i];
            w_pu_ids[i*C_MAX_QBITS +: BITQPRT]   = pu_prt[i*BITQPRT +: BITQPRT];
        end
        for (int i = 0; i < NUMPOPT; i++) begin
            w_pop_ext[i]                         = pop[i];
            w_po_ids[i*C_MAX_QBITS +: BITQPRT]   = po_prt[i*BITQPRT +: BITQPRT];
        end
    end

    // Pops are checked against the registered count only (no push bypass)
    always_comb begin
        w_p   = ready ? count_hits(w_push_ext, w_pu_ids, C_QID) : 32'd0;
        w_d   = ready ? count_hits(w_pop_ext,  w_po_ids, C_QID) : 32'd0;
        w_occ = 32'(occ_q);
        uflow = (w_d > w_occ);
        w_eff = uflow ? w_occ : w_d;
        w_sum = w_occ + w_p - w_eff;
        oflow = (w_sum > C_QCAP);
        occ_d = oflow ? C_QCAP[BITADDR:0] : w_sum[BITADDR:0];
    end

    assign occ_nxt = occ_d;

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef QOCC_MON_SVA_EN
    a_pop_at_zero: assert property (@(posedge clk) disable iff (!rst || !ready)
        !((w_d != 32'd0) && (occ_q == '0)))
        else $error("[ERROR:memoir:%m:%0t] pop to queue %0d at zero count", $time, QID);

    a_over_cap: assert property (@(posedge clk) disable iff (!rst || !ready)
        !(w_sum > C_QCAP))
        else $error("[ERROR:memoir:%m:%0t] queue %0d count exceeds cap", $time, QID);
`endif

endmodule
`default_nettype wire

// File: rtl/algo_mrmw_qocc_mon.sv
`default_nettype none
// ============================================================================
// Module      : algo_mrmw_qocc_mon
// Description : Per-queue occupancy monitor snooping a multi-port push/pop
//               bus. One qocc_lane per queue; this level holds first-error
//               capture, sticky flags, the error-event counter, the total
//               occupancy and the CPU read port.
//               Optional macro QOCC_MON_SVA_EN compiles in assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module algo_mrmw_qocc_mon
    import qocc_pkg::*;
#(
    parameter int NUMQPRT = 64,
    parameter int BITQPRT = 6,
    parameter int NUMADDR = 8192,
    parameter int BITADDR = 13,
    parameter int NUMPUPT = 2,
    parameter int NUMPOPT = 2,
    parameter int QCAP    = NUMADDR,
    parameter int BITECNT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ready,
    input  logic [NUMPUPT-1:0]         push,
    input  logic [NUMPUPT*BITQPRT-1:0] pu_prt,
    input  logic [NUMPOPT-1:0]         pop,
    input  logic [NUMPOPT*BITQPRT-1:0] po_prt,
    input  logic                       err_clr,
    input  logic                       cp_read,
    input  logic [BITQPRT-1:0]         cp_adr,
    output logic                       cp_vld,
    output logic [BITADDR:0]           cp_dout,
    output logic [BITADDR:0]           occ_total,
    output logic                       err_uflow,
    output logic                       err_oflow,
    output logic                       err_vld,
    output logic [BITQPRT-1:0]         err_prt,
    output logic                       err_type,
    output logic [BITECNT-1:0]         err_cnt
);

    localparam logic [31:0] C_TOT_MAX  = (BITADDR + 1 >= 32) ? 32'hFFFF_FFFF
                                                             : ((32'd1 << (BITADDR + 1)) - 32'd1);
    localparam logic [31:0] C_ECNT_MAX = (BITECNT >= 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << BITECNT) - 32'd1);

    logic [BITADDR:0]   lane_occ_nxt [NUMQPRT];
    logic [NUMQPRT-1:0] lane_uflow;
    logic [NUMQPRT-1:0] lane_oflow;

    genvar gq;
    generate
        for (gq = 0; gq < NUMQPRT; gq++) begin : g_lane
            qocc_lane #(
                .QID     (gq),
                .BITQPRT (BITQPRT),
                .BITADDR (BITADDR),
                .NUMPUPT (NUMPUPT),
                .NUMPOPT (NUMPOPT),
                .QCAP    (QCAP)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .ready   (ready),
                .push    (push),
                .pu_prt  (pu_prt),
                .pop     (pop),
                .po_prt  (po_prt),
                .occ_nxt (lane_occ_nxt[gq]),
                .uflow   (lane_uflow[gq]),
                .oflow   (lane_oflow[gq])
            );
        end
    endgenerate

    logic [31:0]        w_events;
    logic [31:0]        w_total;
    logic [31:0]        w_cnt_sum;
    logic               w_any;
    logic [BITQPRT-1:0] w_first_q;
    err_type_e          w_first_type;

    logic               cp_vld_d,    cp_vld_q;
    logic [BITADDR:0]   cp_dout_d,   cp_dout_q;
    logic [BITADDR:0]   occ_total_d, occ_total_q;
    logic               err_uflow_d, err_uflow_q;
    logic               err_oflow_d, err_oflow_q;
    logic               err_vld_d,   err_vld_q;
    logic [BITQPRT-1:0] err_prt_d,   err_prt_q;
    err_type_e          err_type_d,  err_type_q;
    logic [BITECNT-1:0] err_cnt_d,   err_cnt_q;

    // Event count, lowest-numbered erroring queue, and next total occupancy
    always_comb begin
        w_events     = '0;
        w_total      = '0;
        w_first_q    = '0;
        w_first_type = ERR_UFLOW;
        w_any        = |(lane_uflow | lane_oflow);
        for (int q = 0; q < NUMQPRT; q++) begin
            w_events = w_events + {31'd0, lane_uflow[q]} + {31'd0, lane_oflow[q]};
            w_total  = sat_add(w_total, 32'(lane_occ_nxt[q]), C_TOT_MAX);
        end
        for (int q = NUMQPRT - 1; q >= 0; q--) begin
            if (lane_uflow[q] || lane_oflow[q]) begin
                w_first_q    = BITQPRT'(q);
                w_first_type = lane_uflow[q] ? ERR_UFLOW : ERR_OFLOW;
            end
        end
        w_cnt_sum = sat_add(32'(err_cnt_q), w_events, C_ECNT_MAX);
    end

    // Next state of the error bookkeeping, total and CPU read registers
    always_comb begin
        err_uflow_d = err_uflow_q;
        err_oflow_d = err_oflow_q;
        err_vld_d   = err_vld_q;
        err_prt_d   = err_prt_q;
        err_type_d  = err_type_q;
        err_cnt_d   = err_cnt_q;
        if (err_clr) begin
            // Clear wins; a same-cycle error is deliberately dropped
            err_uflow_d = 1'b0;
            err_oflow_d = 1'b0;
            err_vld_d   = 1'b0;
            err_prt_d   = '0;
            err_type_d  = ERR_UFLOW;
            err_cnt_d   = '0;
        end else begin
            err_uflow_d = err_uflow_q | (|lane_uflow);
            err_oflow_d = err_oflow_q | (|lane_oflow);
            err_cnt_d   = w_cnt_sum[BITECNT-1:0];
            if (!err_vld_q && w_any) begin
                err_vld_d  = 1'b1;
                err_prt_d  = w_first_q;
                err_type_d = w_first_type;
            end
        end
        occ_total_d = w_total[BITADDR:0];
        cp_vld_d    = cp_read;
        cp_dout_d   = cp_read ? lane_occ_nxt[cp_adr] : cp_dout_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cp_vld_q    <= 1'b0;
            cp_dout_q   <= '0;
            occ_total_q <= '0;
            err_uflow_q <= 1'b0;
            err_oflow_q <= 1'b0;
            err_vld_q   <= 1'b0;
            err_prt_q   <= '0;
            err_type_q  <= ERR_UFLOW;
            err_cnt_q   <= '0;
        end else begin
            cp_vld_q    <= cp_vld_d;
            cp_dout_q   <= cp_dout_d;
            occ_total_q <= occ_total_d;
            err_uflow_q <= err_uflow_d;
            err_oflow_q <= err_oflow_d;
            err_vld_q   <= err_vld_d;
            err_prt_q   <= err_prt_d;
            err_type_q  <= err_type_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cp_vld    = cp_vld_q;
    assign cp_dout   = cp_dout_q;
    assign occ_total = occ_total_q;
    assign err_uflow = err_uflow_q;
    assign err_oflow = err_oflow_q;
    assign err_vld   = err_vld_q;
    assign err_prt   = err_prt_q;
    assign err_type  = err_type_q;
    assign err_cnt   = err_cnt_q;

`ifdef QOCC_MON_SVA_EN
    a_cp_vld_after_read: assert property (@(posedge clk) disable iff (!rst || !ready)
        cp_read |=> cp_vld)
        else $error("[ERROR:memoir:%m:%0t] missing cp_vld for queue %0d", $time, $past(cp_adr));

    a_cp_vld_only_after_read: assert property (@(posedge clk) disable iff (!rst || !ready)
        cp_vld |-> $past(cp_read))
        else $error("[ERROR:memoir:%m:%0t] spurious cp_vld for queue %0d", $time, $past(cp_adr));
`endif

endmodule
`default_nettype wire
